// File: rtl/mult_share_arbiter.sv
// Round-robin front end that lets two requesters share one external 4x4 multiplier.
// Operands are registered toward the multiplier; the product is registered and returned with a done pulse.
module mult_share_arbiter #(
    parameter int WIDTH       = 4,
    parameter int CALC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    output logic                 gnt0,
    output logic                 done0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt1,
    output logic                 done1,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic [2*WIDTH-1:0]   p_out,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter preload: the last settle cycle is the one where the count reads zero.
    localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 owner_r;
    logic                 owner_nxt_s;
    logic                 last_r;
    logic                 last_nxt_s;
    logic [3:0]           cnt_r;
    logic [3:0]           cnt_nxt_s;
    logic                 win_s;
    logic                 gnt0_nxt_s;
    logic                 gnt1_nxt_s;
    logic                 done0_nxt_s;
    logic                 done1_nxt_s;
    logic                 busy_nxt_s;
    logic [WIDTH-1:0]     mul_a_nxt_s;
    logic [WIDTH-1:0]     mul_b_nxt_s;
    logic [2*WIDTH-1:0]   p_out_nxt_s;

    // Winner selection, next-state and next-output computation.
    always_comb begin
        if (req0 && req1) begin
            win_s = ~last_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end

        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        gnt0_nxt_s  = 1'b0;
        gnt1_nxt_s  = 1'b0;
        done0_nxt_s = 1'b0;
        done1_nxt_s = 1'b0;
        mul_a_nxt_s = mul_a;
        mul_b_nxt_s = mul_b;
        p_out_nxt_s = p_out;

        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    mul_a_nxt_s = win_s ? a1 : a0;
                    mul_b_nxt_s = win_s ? b1 : b0;
                    owner_nxt_s = win_s;
                    last_nxt_s  = win_s;
                    gnt0_nxt_s  = ~win_s;
                    gnt1_nxt_s  = win_s;
                    cnt_nxt_s   = CNT_INIT;
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r != 4'd0) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    p_out_nxt_s = mul_p;
                    done0_nxt_s = ~owner_r;
                    done1_nxt_s = owner_r;
                    state_nxt_s = DONE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and registered outputs; reset leaves the pointer on requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            cnt_r   <= 4'd0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            busy    <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            p_out   <= '0;
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gnt0    <= gnt0_nxt_s;
            gnt1    <= gnt1_nxt_s;
            done0   <= done0_nxt_s;
            done1   <= done1_nxt_s;
            busy    <= busy_nxt_s;
            mul_a   <= mul_a_nxt_s;
            mul_b   <= mul_b_nxt_s;
            p_out   <= p_out_nxt_s;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: one instance with 1 settle cycle, one with 3,
// each driving a behavioural multiplier model.
module tb_mult_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] a0 = 4'd0;
    logic [3:0] b0 = 4'd0;
    logic [3:0] a1 = 4'd0;
    logic [3:0] b1 = 4'd0;

    logic       d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_busy;
    logic [3:0] d1_mul_a, d1_mul_b;
    logic [7:0] d1_mul_p, d1_p_out;
    logic       d3_gnt0, d3_gnt1, d3_done0, d3_done1, d3_busy;
    logic [3:0] d3_mul_a, d3_mul_b;
    logic [7:0] d3_mul_p, d3_p_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign d1_mul_p = {4'd0, d1_mul_a} * {4'd0, d1_mul_b};
    assign d3_mul_p = {4'd0, d3_mul_a} * {4'd0, d3_mul_b};

    mult_share_arbiter #(.WIDTH(4), .CALC_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(d1_gnt0), .done0(d1_done0),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(d1_gnt1), .done1(d1_done1),
        .mul_a(d1_mul_a), .mul_b(d1_mul_b), .mul_p(d1_mul_p),
        .p_out(d1_p_out), .busy(d1_busy)
    );

    mult_share_arbiter #(.WIDTH(4), .CALC_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(d3_gnt0), .done0(d3_done0),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(d3_gnt1), .done1(d3_done1),
        .mul_a(d3_mul_a), .mul_b(d3_mul_b), .mul_p(d3_mul_p),
        .p_out(d3_p_out), .busy(d3_busy)
    );

    task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        #1;
        // Reset held for two cycles.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_vec("rst_gnt",   {6'd0, d1_gnt1, d1_gnt0}, 8'd0);
        check_vec("rst_done",  {6'd0, d1_done1, d1_done0}, 8'd0);
        check_vec("rst_busy",  {7'd0, d1_busy}, 8'd0);
        check_vec("rst_p_out", d1_p_out, 8'd0);
        check_vec("rst_mul",   {d1_mul_a, d1_mul_b}, 8'd0);
        check_vec("rst_busy3", {7'd0, d3_busy}, 8'd0);

        // Single request, 7*9.
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd9;
        tick();
        check_vec("single_gnt0", {7'd0, d1_gnt0}, 8'd1);
        check_vec("single_busy", {7'd0, d1_busy}, 8'd1);
        req0 = 1'b0;
        tick();
        check_vec("single_done0", {7'd0, d1_done0}, 8'd1);
        check_vec("single_p",     d1_p_out, 8'd63);
        check_vec("single_gnt_low", {6'd0, d1_gnt1, d1_gnt0}, 8'd0);
        tick();
        check_vec("single_idle", {7'd0, d1_busy}, 8'd0);
        check_vec("single_done_low", {6'd0, d1_done1, d1_done0}, 8'd0);

        // Tie then alternation with both requests held.
        do_reset();
        req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
        req1 = 1'b1; a1 = 4'd3;  b1 = 4'd5;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            tick();
            check_vec("alt_gnt_excl",  {7'd0, d1_gnt0 & d1_gnt1}, 8'd0);
            check_vec("alt_done_excl", {7'd0, d1_done0 & d1_done1}, 8'd0);
            if (d1_done0 || d1_done1) begin
                check_vec("alt_who", {6'd0, d1_done1, d1_done0}, (k % 2 == 0) ? 8'd1 : 8'd2);
                check_vec("alt_p",   d1_p_out, (k % 2 == 0) ? 8'd225 : 8'd15);
                k++;
            end
        end
        check_vec("alt_count", 8'(k), 8'd4);
        req0 = 1'b0; req1 = 1'b0;

        // Operand change in the grant cycle must not affect the result.
        do_reset();
        req0 = 1'b1; a0 = 4'd2; b0 = 4'd3;
        tick();
        check_vec("cap_gnt0", {7'd0, d1_gnt0}, 8'd1);
        a0 = 4'd9; req0 = 1'b0;
        tick();
        check_vec("cap_done0", {7'd0, d1_done0}, 8'd1);
        check_vec("cap_p",     d1_p_out, 8'd6);

        // Three settle cycles: gnt at t+1, done at t+4, busy t+1..t+4.
        do_reset();
        req1 = 1'b1; a1 = 4'd4; b1 = 4'd4;
        tick();
        check_vec("lat_gnt1", {6'd0, d3_gnt1, d3_gnt0}, 8'd2);
        check_vec("lat_busy1", {7'd0, d3_busy}, 8'd1);
        req1 = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            tick();
            check_vec("lat_no_done", {6'd0, d3_done1, d3_done0}, 8'd0);
            check_vec("lat_busy_mid", {7'd0, d3_busy}, 8'd1);
            check_vec("lat_no_gnt", {6'd0, d3_gnt1, d3_gnt0}, 8'd0);
        end
        tick();
        check_vec("lat_done1", {6'd0, d3_done1, d3_done0}, 8'd2);
        check_vec("lat_p",     d3_p_out, 8'd16);
        check_vec("lat_busy4", {7'd0, d3_busy}, 8'd1);
        tick();
        check_vec("lat_idle", {7'd0, d3_busy}, 8'd0);

        // Reset while a requester-1 transaction is in CALC.
        do_reset();
        req1 = 1'b1; a1 = 4'd4; b1 = 4'd4;
        tick();
        req1 = 1'b0;
        tick();
        check_vec("abort_in_calc", {7'd0, d3_busy}, 8'd1);
        do_reset();
        check_vec("abort_p",    d3_p_out, 8'd0);
        check_vec("abort_busy", {7'd0, d3_busy}, 8'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_vec("abort_no_done", {6'd0, d3_done1, d3_done0}, 8'd0);
        end
        req0 = 1'b1; a0 = 4'd1; b0 = 4'd2;
        req1 = 1'b1; a1 = 4'd3; b1 = 4'd3;
        tick();
        check_vec("abort_tie_gnt", {6'd0, d3_gnt1, d3_gnt0}, 8'd1);
        check_vec("abort_tie_mul", {d3_mul_a, d3_mul_b}, 8'h12);
        req0 = 1'b0; req1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
